// File: rtl/counter_pkg.sv
// Shared definitions for the counters-and-registers library: direction
// encodings and the prescaler counter width helper.
package counter_pkg;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // Width of a counter that must hold 0..p-1, never narrower than one bit.
   function automatic int presc_width(input int p);
      int w;
      w = $clog2(p);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enable prescaler: asserts step on every PRESCALE-th en-qualified cycle.
// With PRESCALE = 1 the counter is pinned at zero, so step reduces to en.
module counter_prescaler
   import counter_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en,
   input  logic clr,
   output logic step
);

   localparam int PW = presc_width(PRESCALE);
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   if (PRESCALE < 1) begin : g_bad_prescale
      $fatal(1, "counter_prescaler: PRESCALE must be >= 1");
   end

   logic [PW-1:0] pcnt;

   assign step = en && (pcnt == LAST);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pcnt <= '0;
      end else if (clr) begin
         pcnt <= '0;
      end else if (en) begin
         pcnt <= (pcnt == LAST) ? '0 : pcnt + 1'b1;
      end
   end

endmodule

// File: rtl/updown_mod_counter.sv
// Synchronous up/down modulo counter with parallel load, prescaler, terminal
// count and wrap pulse. Define UPDOWN_MOD_COUNTER_SAT_EN for a saturating build.
module updown_mod_counter
   import counter_pkg::*;
#(
   parameter int WIDTH    = 3,
   parameter int MODULUS  = 2**WIDTH,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] QMAX = WIDTH'(MODULUS - 1);

   if (WIDTH < 1) begin : g_bad_width
      $fatal(1, "updown_mod_counter: WIDTH must be >= 1");
   end
   if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
      $fatal(1, "updown_mod_counter: MODULUS must lie in 2..2**WIDTH");
   end
   if (PRESCALE < 1) begin : g_bad_prescale
      $fatal(1, "updown_mod_counter: PRESCALE must be >= 1");
   end

   logic             step;
   logic [WIDTH-1:0] q_load;
   logic [WIDTH-1:0] q_step;

   counter_prescaler #(
      .PRESCALE(PRESCALE)
   ) u_prescaler (
      .clk    (clk),
      .reset_n(reset_n),
      .en     (en),
      .clr    (load),
      .step   (step)
   );

   // Clamp only exists when some load values lie outside the count range.
   if (longint'(MODULUS) < (longint'(1) << WIDTH)) begin : g_clamp
      assign q_load = (load_val > QMAX) ? QMAX : load_val;
   end else begin : g_no_clamp
      assign q_load = load_val;
   end

   assign tc = (up_dn == DIR_UP) ? (q == QMAX) : (q == '0);

`ifdef UPDOWN_MOD_COUNTER_SAT_EN
   always_comb begin
      q_step = q;
      if (up_dn == DIR_UP) begin
         if (q != QMAX) q_step = q + 1'b1;
      end else begin
         if (q != '0) q_step = q - 1'b1;
      end
   end

   assign wrap = 1'b0;
`else
   logic crossed;

   always_comb begin
      q_step  = q;
      crossed = 1'b0;
      if (up_dn == DIR_UP) begin
         if (q == QMAX) begin
            q_step  = '0;
            crossed = 1'b1;
         end else begin
            q_step = q + 1'b1;
         end
      end else begin
         if (q == '0) begin
            q_step  = QMAX;
            crossed = 1'b1;
         end else begin
            q_step = q - 1'b1;
         end
      end
   end

   logic wrap_r;

   always_ff @(posedge clk) begin
      if (!reset_n || load) begin
         wrap_r <= 1'b0;
      end else begin
         wrap_r <= step && crossed;
      end
   end

   assign wrap = wrap_r;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         q <= '0;
      end else if (load) begin
         q <= q_load;
      end else if (step) begin
         q <= q_step;
      end
   end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Self-checking bench: three counter configurations share one stimulus stream
// and are compared against a modulo-arithmetic reference model.
module tb_updown_mod_counter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_n, en, up_dn, load;
   logic [2:0] load_val;

   logic [2:0] q0, q1;
   logic       q2;
   logic       tc0, tc1, tc2;
   logic       wrap0, wrap1, wrap2;

   updown_mod_counter #(.WIDTH(3), .MODULUS(6), .PRESCALE(1)) u0 (
      .clk(clk), .reset_n(reset_n), .en(en), .up_dn(up_dn), .load(load),
      .load_val(load_val), .q(q0), .tc(tc0), .wrap(wrap0));

   updown_mod_counter #(.WIDTH(3), .MODULUS(6), .PRESCALE(3)) u1 (
      .clk(clk), .reset_n(reset_n), .en(en), .up_dn(up_dn), .load(load),
      .load_val(load_val), .q(q1), .tc(tc1), .wrap(wrap1));

   updown_mod_counter #(.WIDTH(1), .MODULUS(2), .PRESCALE(1)) u2 (
      .clk(clk), .reset_n(reset_n), .en(en), .up_dn(up_dn), .load(load),
      .load_val(load_val[0:0]), .q(q2), .tc(tc2), .wrap(wrap2));

   int checks = 0;
   int errors = 0;

   int unsigned modv [3] = '{6, 6, 2};
   int unsigned pre  [3] = '{1, 3, 1};
   int unsigned mq   [3];
   int unsigned mpc  [3];
   int unsigned mw   [3];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] dut_q(input int i);
      case (i)
         0: return {29'd0, q0};
         1: return {29'd0, q1};
         default: return {31'd0, q2};
      endcase
   endfunction

   function automatic logic [31:0] dut_tc(input int i);
      case (i)
         0: return {31'd0, tc0};
         1: return {31'd0, tc1};
         default: return {31'd0, tc2};
      endcase
   endfunction

   function automatic logic [31:0] dut_wrap(input int i);
      case (i)
         0: return {31'd0, wrap0};
         1: return {31'd0, wrap1};
         default: return {31'd0, wrap2};
      endcase
   endfunction

   function automatic int unsigned model_tc(input int i);
      if (up_dn) return (mq[i] == modv[i] - 1) ? 1 : 0;
      return (mq[i] == 0) ? 1 : 0;
   endfunction

   // Apply one rising edge to the reference model using the current inputs.
   task automatic model_edge();
      for (int i = 0; i < 3; i++) begin
         int unsigned lv;
         lv = (i == 2) ? int'(load_val[0]) : int'(load_val);
         mw[i] = 0;
         if (!reset_n) begin
            mq[i]  = 0;
            mpc[i] = 0;
         end else if (load) begin
            mq[i]  = (lv > modv[i] - 1) ? modv[i] - 1 : lv;
            mpc[i] = 0;
         end else if (en) begin
            if (mpc[i] + 1 < pre[i]) begin
               mpc[i]++;
            end else begin
               mpc[i] = 0;
`ifdef UPDOWN_MOD_COUNTER_SAT_EN
               if (up_dn && mq[i] < modv[i] - 1) mq[i]++;
               else if (!up_dn && mq[i] > 0) mq[i]--;
`else
               if (up_dn) begin
                  mw[i] = (mq[i] == modv[i] - 1) ? 1 : 0;
                  mq[i] = (mq[i] + 1) % modv[i];
               end else begin
                  mw[i] = (mq[i] == 0) ? 1 : 0;
                  mq[i] = (mq[i] + modv[i] - 1) % modv[i];
               end
`endif
            end
         end
      end
   endtask

   // Called just after a falling edge; returns just after the next falling edge.
   task automatic cyc(input logic r, input logic e, input logic u,
                      input logic l, input logic [2:0] v);
      reset_n  = r;
      en       = e;
      up_dn    = u;
      load     = l;
      load_val = v;
      #1;
      for (int i = 0; i < 3; i++) chk($sformatf("tc_pre[%0d]", i), dut_tc(i), model_tc(i));
      @(posedge clk);
      model_edge();
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("q[%0d]", i),    dut_q(i),    mq[i]);
         chk($sformatf("wrap[%0d]", i), dut_wrap(i), mw[i]);
         chk($sformatf("tc[%0d]", i),   dut_tc(i),   model_tc(i));
      end
      @(negedge clk);
   endtask

   initial begin
      reset_n  = 1'b0;
      en       = 1'b0;
      up_dn    = 1'b1;
      load     = 1'b0;
      load_val = '0;
      @(posedge clk);
      model_edge();
      @(negedge clk);

      repeat (2) cyc(0, 0, 1, 0, 0);
      chk("reset_q0", dut_q(0), 0);
      repeat (7) cyc(1, 1, 1, 0, 0);

      cyc(0, 0, 0, 0, 0);
      repeat (8) cyc(1, 1, 0, 0, 0);

      cyc(1, 1, 1, 1, 3);
      chk("load3_q0", dut_q(0), 3);
      cyc(1, 1, 1, 1, 7);
      chk("clamp7_q0", dut_q(0), 5);

      cyc(0, 0, 1, 0, 0);
      repeat (4) cyc(1, 1, 1, 0, 0);
      repeat (2) cyc(1, 0, 1, 0, 0);
      repeat (5) cyc(1, 1, 1, 0, 0);

      cyc(0, 0, 1, 0, 0);
      repeat (4) cyc(1, 1, 1, 0, 0);
      chk("dir_q0_4", dut_q(0), 4);
      repeat (2) cyc(1, 1, 0, 0, 0);
      chk("dir_q0_2", dut_q(0), 2);
      cyc(0, 1, 0, 0, 0);
      chk("midreset_q0", dut_q(0), 0);

      repeat (8) cyc(1, 1, 1, 0, 0);
      repeat (8) cyc(1, 1, 0, 0, 0);

      repeat (400) begin
         cyc($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0, 1'($urandom),
             $urandom_range(0, 15) == 0, 3'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
